// File: rtl/frv_mem_arbiter_pkg.sv
// frv_mem_arbiter_pkg: shared constants and helpers for the fetch/data memory arbiter
package frv_mem_arbiter_pkg;

  localparam int XL = 31;

  localparam logic FRV_ARB_OWN_FETCH = 1'b0;
  localparam logic FRV_ARB_OWN_DATA  = 1'b1;

  localparam int FRV_ARB_STREAK_W = 4;

  typedef logic [XL:0]               xword_t;
  typedef logic [FRV_ARB_STREAK_W-1:0] streak_t;

  function automatic streak_t streak_inc(input streak_t s, input streak_t m);
    return (s < m) ? s + 1'b1 : m;
  endfunction

endpackage

// File: rtl/frv_mem_arbiter.sv
// frv_mem_arbiter: data-priority arbiter of fetch and data ports onto one memory port
module frv_mem_arbiter
  import frv_mem_arbiter_pkg::*;
#(
  parameter int ARB_MAX_DSTREAK   = 4,
  parameter int ARB_DATA_PRIORITY = 1
) (
  input  logic         g_clk,
  input  logic         g_resetn,
  input  logic         imem_cen,
  input  logic         imem_wen,
  input  logic [3:0]   imem_strb,
  input  logic [XL:0]  imem_addr,
  input  logic [XL:0]  imem_wdata,
  output logic         imem_stall,
  output logic         imem_error,
  output logic [XL:0]  imem_rdata,
  input  logic         dmem_cen,
  input  logic         dmem_wen,
  input  logic [3:0]   dmem_strb,
  input  logic [XL:0]  dmem_addr,
  input  logic [XL:0]  dmem_wdata,
  output logic         dmem_stall,
  output logic         dmem_error,
  output logic [XL:0]  dmem_rdata,
  output logic         mem_cen,
  output logic         mem_wen,
  output logic [3:0]   mem_strb,
  output logic [XL:0]  mem_addr,
  output logic [XL:0]  mem_wdata,
  input  logic         mem_stall,
  input  logic         mem_error,
  input  logic [XL:0]  mem_rdata
);

  localparam streak_t L_MAX = FRV_ARB_STREAK_W'(ARB_MAX_DSTREAK);

  logic    r_lock;
  logic    r_lock_owner;
  streak_t r_streak;

  logic w_sel_v;
  logic w_sel_d;
  logic w_gnt_i;
  logic w_gnt_d;
  logic w_hold;

  // pick an owner: a locked transaction keeps it, otherwise data wins ties until the streak cap
  always_comb begin
    w_sel_v = 1'b0;
    w_sel_d = FRV_ARB_OWN_FETCH;
    if (!g_resetn) begin
      w_sel_v = 1'b0;
    end else if (r_lock) begin
      w_sel_v = 1'b1;
      w_sel_d = r_lock_owner;
    end else if (imem_cen && dmem_cen) begin
      w_sel_v = 1'b1;
      w_sel_d = (ARB_DATA_PRIORITY != 0) && (r_streak < L_MAX);
    end else if (imem_cen || dmem_cen) begin
      w_sel_v = 1'b1;
      w_sel_d = dmem_cen;
    end
  end

  // a grant only counts while its owner still requests, so an abandoned lock drops mem_cen at once
  assign w_gnt_d = w_sel_v &&  w_sel_d && dmem_cen;
  assign w_gnt_i = w_sel_v && !w_sel_d && imem_cen;
  assign w_hold  = mem_cen && mem_stall;

  assign mem_cen   = w_gnt_d || w_gnt_i;
  assign mem_wen   = w_gnt_d ? dmem_wen   : (w_gnt_i && imem_wen);
  assign mem_strb  = w_gnt_d ? dmem_strb  : w_gnt_i ? imem_strb  : '0;
  assign mem_addr  = w_gnt_d ? dmem_addr  : w_gnt_i ? imem_addr  : '0;
  assign mem_wdata = w_gnt_d ? dmem_wdata : w_gnt_i ? imem_wdata : '0;

  assign imem_stall = imem_cen && (w_gnt_i ? mem_stall : 1'b1);
  assign dmem_stall = dmem_cen && (w_gnt_d ? mem_stall : 1'b1);
  assign imem_rdata = mem_rdata;
  assign dmem_rdata = mem_rdata;
  assign imem_error = mem_error && w_gnt_i;
  assign dmem_error = mem_error && w_gnt_d;

  // lock follows stalled transactions; streak counts data completions that made fetch wait
  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      r_lock       <= 1'b0;
      r_lock_owner <= FRV_ARB_OWN_FETCH;
      r_streak     <= '0;
    end else begin
      r_lock <= w_hold;
      if (w_hold) r_lock_owner <= w_gnt_d ? FRV_ARB_OWN_DATA : FRV_ARB_OWN_FETCH;
      r_streak <= (!imem_cen || (w_gnt_i && !mem_stall)) ? '0 :
                  (w_gnt_d && !mem_stall) ? streak_inc(r_streak, L_MAX) : r_streak;
    end
  end

endmodule

// File: tb/tb_frv_mem_arbiter.sv
// tb_frv_mem_arbiter: directed stimulus with a completion scoreboard for the memory arbiter
module tb_frv_mem_arbiter;

  localparam logic [31:0] K = 32'h5A5A_5A5A;

  typedef struct {
    logic        d;
    logic [31:0] a;
    logic        e;
  } exp_t;

  logic        g_clk = 1'b0;
  logic        g_resetn;
  logic        imem_cen, imem_wen, dmem_cen, dmem_wen;
  logic [3:0]  imem_strb, dmem_strb, mem_strb;
  logic [31:0] imem_addr, imem_wdata, dmem_addr, dmem_wdata;
  logic        imem_stall, imem_error, dmem_stall, dmem_error;
  logic [31:0] imem_rdata, dmem_rdata;
  logic        mem_cen, mem_wen, mem_stall, mem_error;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  exp_t q[$];
  int   n_chk = 0;
  int   n_bad = 0;

  always #5 g_clk = ~g_clk;

  assign mem_rdata = mem_addr ^ K;

  frv_mem_arbiter #(.ARB_MAX_DSTREAK(4), .ARB_DATA_PRIORITY(1)) dut (
    .g_clk(g_clk), .g_resetn(g_resetn),
    .imem_cen(imem_cen), .imem_wen(imem_wen), .imem_strb(imem_strb),
    .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .imem_stall(imem_stall), .imem_error(imem_error), .imem_rdata(imem_rdata),
    .dmem_cen(dmem_cen), .dmem_wen(dmem_wen), .dmem_strb(dmem_strb),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_stall(dmem_stall), .dmem_error(dmem_error), .dmem_rdata(dmem_rdata),
    .mem_cen(mem_cen), .mem_wen(mem_wen), .mem_strb(mem_strb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_stall(mem_stall), .mem_error(mem_error), .mem_rdata(mem_rdata)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic push(input logic d, input logic [31:0] a, input logic e);
    exp_t x;
    x.d = d;
    x.a = a;
    x.e = e;
    q.push_back(x);
  endtask

  task automatic step(input logic rn, input logic ic, input logic [31:0] ia,
                      input logic dc, input logic [31:0] da, input logic ms, input logic me);
    @(posedge g_clk);
    #1;
    g_resetn  = rn;
    imem_cen  = ic;
    imem_addr = ia;
    dmem_cen  = dc;
    dmem_addr = da;
    mem_stall = ms;
    mem_error = me;
    #3;
  endtask

  always @(negedge g_clk) begin
    exp_t e;
    logic dn;
    if (g_resetn && ((imem_cen && !imem_stall) || (dmem_cen && !dmem_stall))) begin
      dn = dmem_cen && !dmem_stall;
      if (q.size() == 0) begin
        n_chk++;
        n_bad++;
        $display("FAIL unexpected_completion: got port=%0d addr=%h expected none", dn, mem_addr);
      end else begin
        e = q.pop_front();
        chk("port", {31'd0, dn}, {31'd0, e.d});
        chk("addr", mem_addr, e.a);
        chk("rdata", dn ? dmem_rdata : imem_rdata, e.a ^ K);
        chk("derr", {31'd0, dmem_error}, {31'd0, e.d & e.e});
        chk("ierr", {31'd0, imem_error}, {31'd0, !e.d & e.e});
      end
    end
  end

  initial begin
    g_resetn = 1'b0;
    imem_cen = 1'b0; imem_wen = 1'b0; imem_strb = 4'h0; imem_addr = '0; imem_wdata = '0;
    dmem_cen = 1'b0; dmem_wen = 1'b0; dmem_strb = 4'h0; dmem_addr = '0; dmem_wdata = '0;
    mem_stall = 1'b0; mem_error = 1'b0;
    step(0, 1, 32'h8000_0000, 1, 32'h0000_1000, 0, 0);
    chk("rst_mem_cen", {31'd0, mem_cen}, 32'd0);
    chk("rst_istall", {31'd0, imem_stall}, 32'd1);
    chk("rst_dstall", {31'd0, dmem_stall}, 32'd1);
    step(0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("idle_mem_cen", {31'd0, mem_cen}, 32'd0);
    chk("idle_istall", {31'd0, imem_stall}, 32'd0);
    push(0, 32'h8000_0000, 0);
    step(1, 1, 32'h8000_0000, 0, 0, 0, 0);
    chk("f_mem_cen", {31'd0, mem_cen}, 32'd1);
    chk("f_mem_addr", mem_addr, 32'h8000_0000);
    chk("f_dstall", {31'd0, dmem_stall}, 32'd0);
    push(1, 32'h0000_1000, 0);
    step(1, 1, 32'h8000_0004, 1, 32'h0000_1000, 0, 0);
    chk("tie_addr", mem_addr, 32'h0000_1000);
    chk("tie_istall", {31'd0, imem_stall}, 32'd1);
    push(0, 32'h8000_0004, 0);
    step(1, 1, 32'h8000_0004, 0, 0, 0, 0);
    chk("tie_next_addr", mem_addr, 32'h8000_0004);
    for (int i = 0; i < 4; i++) push(1, 32'h0000_2000 + 32'(4 * i), 0);
    push(0, 32'h8000_0008, 0);
    push(1, 32'h0000_2010, 0);
    push(0, 32'h8000_000C, 0);
    for (int i = 0; i < 4; i++) step(1, 1, 32'h8000_0008, 1, 32'h0000_2000 + 32'(4 * i), 0, 0);
    step(1, 1, 32'h8000_0008, 1, 32'h0000_2010, 0, 0);
    chk("streak_fetch_addr", mem_addr, 32'h8000_0008);
    chk("streak_dstall", {31'd0, dmem_stall}, 32'd1);
    step(1, 1, 32'h8000_000C, 1, 32'h0000_2010, 0, 0);
    chk("streak_resume_addr", mem_addr, 32'h0000_2010);
    step(1, 1, 32'h8000_000C, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 32'h0000_3000, 1, 0);
    chk("lock_dstall", {31'd0, dmem_stall}, 32'd1);
    step(1, 1, 32'h8000_0010, 1, 32'h0000_3000, 1, 0);
    chk("lock_addr2", mem_addr, 32'h0000_3000);
    chk("lock_istall2", {31'd0, imem_stall}, 32'd1);
    step(1, 1, 32'h8000_0010, 1, 32'h0000_3000, 1, 0);
    chk("lock_addr3", mem_addr, 32'h0000_3000);
    push(1, 32'h0000_3000, 0);
    push(0, 32'h8000_0010, 0);
    step(1, 1, 32'h8000_0010, 1, 32'h0000_3000, 0, 0);
    chk("lock_istall4", {31'd0, imem_stall}, 32'd1);
    step(1, 1, 32'h8000_0010, 0, 0, 0, 0);
    chk("lock_after_addr", mem_addr, 32'h8000_0010);
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 32'h8000_0020, 0, 0, 1, 0);
    step(1, 1, 32'h8000_0020, 1, 32'h0000_4000, 1, 0);
    chk("abn_locked_addr", mem_addr, 32'h8000_0020);
    chk("abn_dstall", {31'd0, dmem_stall}, 32'd1);
    step(1, 0, 0, 1, 32'h0000_4000, 1, 0);
    chk("abn_mem_cen", {31'd0, mem_cen}, 32'd0);
    chk("abn_dstall2", {31'd0, dmem_stall}, 32'd1);
    push(1, 32'h0000_4000, 0);
    step(1, 0, 0, 1, 32'h0000_4000, 0, 0);
    chk("abn_data_addr", mem_addr, 32'h0000_4000);
    step(1, 0, 0, 0, 0, 0, 0);
    dmem_wen = 1'b1; dmem_strb = 4'hF; dmem_wdata = 32'hDEAD_BEEF;
    imem_wen = 1'b1; imem_strb = 4'h3; imem_wdata = 32'h1234_5678;
    push(1, 32'h0000_5000, 1);
    push(0, 32'h8000_0030, 0);
    step(1, 1, 32'h8000_0030, 1, 32'h0000_5000, 0, 1);
    chk("err_wdata_d", mem_wdata, 32'hDEAD_BEEF);
    chk("err_strb_d", {28'd0, mem_strb}, 32'hF);
    step(1, 1, 32'h8000_0030, 0, 0, 0, 0);
    chk("wdata_i", mem_wdata, 32'h1234_5678);
    chk("strb_i", {28'd0, mem_strb}, 32'h3);
    chk("wen_i", {31'd0, mem_wen}, 32'd1);
    step(1, 0, 0, 0, 0, 0, 0);
    dmem_wen = 1'b0; imem_wen = 1'b0;
    chk("idle_wen", {31'd0, mem_wen}, 32'd0);
    for (int i = 0; i < 3; i++) push(1, 32'h0000_6000 + 32'(4 * i), 0);
    for (int i = 0; i < 3; i++) step(1, 1, 32'h8000_0040, 1, 32'h0000_6000 + 32'(4 * i), 0, 0);
    step(1, 1, 32'h8000_0040, 1, 32'h0000_600C, 1, 0);
    chk("rstx_addr", mem_addr, 32'h0000_600C);
    step(0, 1, 32'h8000_0040, 1, 32'h0000_600C, 1, 0);
    chk("rstx_mem_cen", {31'd0, mem_cen}, 32'd0);
    chk("rstx_istall", {31'd0, imem_stall}, 32'd1);
    chk("rstx_dstall", {31'd0, dmem_stall}, 32'd1);
    for (int i = 0; i < 4; i++) push(1, 32'h0000_7000 + 32'(4 * i), 0);
    push(0, 32'h8000_0040, 0);
    push(1, 32'h0000_7010, 0);
    for (int i = 0; i < 4; i++) step(1, 1, 32'h8000_0040, 1, 32'h0000_7000 + 32'(4 * i), 0, 0);
    step(1, 1, 32'h8000_0040, 1, 32'h0000_7010, 0, 0);
    chk("post_rst_fetch", mem_addr, 32'h8000_0040);
    step(1, 0, 0, 1, 32'h0000_7010, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("queue_empty", 32'(q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
